// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin grant encoder.
// ARB_TIMEOUT_EN (optional) enables the forced release after MAX_HOLD busy cycles.
package arb_pkg;

    localparam int N_REQ    = 8;
    localparam int IDX_W    = $clog2(N_REQ);
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_grant_encoder_onehot_to_idx.sv
// One-hot to binary index converter; for multi-hot input the lowest set bit wins, zero gives 0.
module onehot_to_idx
    import arb_pkg::*;
(
    input  req_vec_t onehot,
    output idx_t     idx
);

    // Descending scan so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (onehot[i]) idx = idx_t'(i);
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and index.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD busy cycles.
module rr_grant_encoder
    import arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t req,
    input  logic     rel,
    output req_vec_t gnt,
    output idx_t     gnt_idx,
    output logic     gnt_valid,
    output logic     timeout
);

    state_t   state;
    idx_t     ptr;
    idx_t     arb_ptr;
    idx_t     win_idx;
    req_vec_t win;
    logic     release_now;
    logic     force_rel;

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    // rel in the limit cycle wins: it is an ordinary release and no timeout is flagged.
    assign force_rel = (state == BUSY) && (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && !rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (state == IDLE || release_now) hold_cnt <= '0;
            else                              hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign release_now = (state == BUSY) && (rel || force_rel);

    // On release the old owner drops to lowest priority in the same cycle's arbitration.
    always_comb begin
        idx_t j;
        arb_ptr = release_now ? idx_t'(gnt_idx + idx_t'(1)) : ptr;
        win     = '0;
        j       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = arb_ptr + idx_t'(k);
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
            end
        end
    end

    onehot_to_idx u_win_enc (
        .onehot (win),
        .idx    (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (state == IDLE || release_now) begin
            if (release_now) ptr <= arb_ptr;
            if (|req) begin
                gnt       <= win;
                gnt_idx   <= win_idx;
                gnt_valid <= 1'b1;
                state     <= BUSY;
            end else begin
                gnt       <= '0;
                gnt_idx   <= '0;
                gnt_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule
